// File: rtl/vcxo_lock_monitor.sv
// Lock/rail status tracker for the VCXO discipline loop with a frozen 8-byte req/ack readout.
// Optional build macro VCXO_LOCK_MONITOR_AVG_EN: frame error field carries the mean of the last 4 samples.
module vcxo_lock_monitor #(
  parameter int TCXO_FREQ_KHZ = 49152,
  parameter int LOCK_TOL      = 2,
  parameter int UNLOCK_TOL    = 8,
  parameter int LOCK_COUNT    = 4
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        meas_valid,
  input  logic [23:0] freq_error_in,
  input  logic [23:0] pwm_in,
  input  logic        rd_start,
  input  logic        rd_ack,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        locked,
  output logic [7:0]  unlock_events
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  snap  [8];
  logic [7:0]  frame [8];
  logic [23:0] err_q, pwm_q, abs_err, err_field;
  logic [7:0]  good_cnt, good_next;
  logic        rail_low, rail_high, sticky;
  logic [3:0]  seq;
  logic        is_good, is_bad, unlock_now, final_ack;

  // The most negative error has no positive twin; clamp instead of wrapping.
  always_comb begin
    if (freq_error_in == 24'h800000)
      abs_err = 24'h7FFFFF;
    else if (freq_error_in[23])
      abs_err = -freq_error_in;
    else
      abs_err = freq_error_in;
  end

  assign is_good    = abs_err <= 24'(LOCK_TOL);
  assign is_bad     = abs_err > 24'(UNLOCK_TOL);
  assign good_next  = (good_cnt >= 8'(LOCK_COUNT)) ? good_cnt : good_cnt + 8'd1;
  assign unlock_now = meas_valid && !is_good && is_bad && locked;
  assign final_ack  = (state == SEND) && rd_ack && (idx == 3'd7);

`ifdef VCXO_LOCK_MONITOR_AVG_EN
  // err_q is the newest sample; hist holds the three before it.
  logic [23:0]        hist [3];
  logic signed [25:0] err_sum;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      hist <= '{default: '0};
    end else if (meas_valid) begin
      hist[0] <= err_q;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
    end
  end

  assign err_sum = $signed({{2{err_q[23]}}, err_q})     + $signed({{2{hist[0][23]}}, hist[0]})
                 + $signed({{2{hist[1][23]}}, hist[1]}) + $signed({{2{hist[2][23]}}, hist[2]});
  assign err_field = 24'(err_sum >>> 2);
`else
  assign err_field = err_q;
`endif

  always_comb begin
    frame[0] = {locked, rail_low, rail_high, sticky, seq};
    frame[1] = err_field[23:16];
    frame[2] = err_field[15:8];
    frame[3] = err_field[7:0];
    frame[4] = pwm_q[23:16];
    frame[5] = pwm_q[15:8];
    frame[6] = pwm_q[7:0];
    frame[7] = unlock_events;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      err_q         <= '0;
      pwm_q         <= '0;
      good_cnt      <= '0;
      locked        <= 1'b0;
      unlock_events <= '0;
      rail_low      <= 1'b0;
      rail_high     <= 1'b0;
    end else if (meas_valid) begin
      err_q     <= freq_error_in;
      pwm_q     <= pwm_in;
      rail_low  <= $signed(pwm_in) <= 24'sd0;
      rail_high <= $signed(pwm_in) >= $signed(24'(TCXO_FREQ_KHZ));
      if (is_good) begin
        good_cnt <= good_next;
        if (good_next == 8'(LOCK_COUNT))
          locked <= 1'b1;
      end else begin
        good_cnt <= '0;
        if (is_bad) begin
          locked <= 1'b0;
          if (locked && unlock_events != 8'hFF)
            unlock_events <= unlock_events + 8'd1;
        end
      end
    end
  end

  // Readout runs from a snapshot so live updates never tear a frame.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state    <= IDLE;
      idx      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      seq      <= '0;
      sticky   <= 1'b0;
      snap     <= '{default: '0};
    end else begin
      if (unlock_now)
        sticky <= 1'b1;
      else if (final_ack)
        sticky <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start) begin
            snap     <= frame;
            rd_data  <= frame[0];
            rd_valid <= 1'b1;
            idx      <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (rd_ack) begin
            if (idx == 3'd7) begin
              state    <= IDLE;
              rd_valid <= 1'b0;
              rd_data  <= '0;
              seq      <= seq + 4'd1;
            end else begin
              idx     <= idx + 3'd1;
              rd_data <= snap[idx + 3'd1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vcxo_lock_monitor.sv
// Self-checking bench for vcxo_lock_monitor: scenario tasks against a rule-level model of
// lock status, counters, rails and the readout frame (honours VCXO_LOCK_MONITOR_AVG_EN).
module tb_vcxo_lock_monitor;
  logic        clk_in = 1'b0;
  logic        reset_in, meas_valid, rd_start, rd_ack;
  logic [23:0] freq_error_in, pwm_in;
  logic [7:0]  rd_data, unlock_events;
  logic        rd_valid, locked;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  vcxo_lock_monitor dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .meas_valid    (meas_valid),
    .freq_error_in (freq_error_in),
    .pwm_in        (pwm_in),
    .rd_start      (rd_start),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .locked        (locked),
    .unlock_events (unlock_events)
  );

  // Reference model state
  bit   m_locked, m_sticky, m_rl, m_rh;
  int   m_run, m_ue, m_seq, m_err, m_pwm;
  int   hist[$];
  logic [7:0] exp_b [8];
  logic [7:0] got_b [8];
  logic       got_v [8];
  logic       end_v;

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    m_locked = 0; m_sticky = 0; m_rl = 0; m_rh = 0;
    m_run = 0; m_ue = 0; m_seq = 0; m_err = 0; m_pwm = 0;
    hist = '{0, 0, 0, 0};
  endtask

  task automatic model_meas(input int e, input int p);
    int a;
    a = (e < 0) ? -e : e;
    if (a > 8388607) a = 8388607;
    if (a <= 2) begin
      m_run = (m_run < 4) ? m_run + 1 : 4;
      if (m_run == 4) m_locked = 1;
    end else if (a > 8) begin
      m_run = 0;
      if (m_locked) begin
        m_ue = (m_ue < 255) ? m_ue + 1 : 255;
        m_sticky = 1;
      end
      m_locked = 0;
    end else begin
      m_run = 0;
    end
    m_err = e; m_pwm = p;
    m_rl = (p <= 0);
    m_rh = (p >= 49152);
    hist.push_front(e);
    void'(hist.pop_back());
  endtask

  task automatic model_frame();
    int ef;
    ef = m_err;
`ifdef VCXO_LOCK_MONITOR_AVG_EN
    ef = (hist[0] + hist[1] + hist[2] + hist[3]) >>> 2;
`endif
    exp_b[0] = {m_locked, m_rl, m_rh, m_sticky, 4'(m_seq)};
    exp_b[1] = 8'(ef >>> 16);
    exp_b[2] = 8'(ef >>> 8);
    exp_b[3] = 8'(ef);
    exp_b[4] = 8'(m_pwm >>> 16);
    exp_b[5] = 8'(m_pwm >>> 8);
    exp_b[6] = 8'(m_pwm);
    exp_b[7] = 8'(m_ue);
  endtask

  task automatic meas(input int e, input int p);
    meas_valid = 1'b1; freq_error_in = 24'(e); pwm_in = 24'(p);
    cycle();
    meas_valid = 1'b0;
    model_meas(e, p);
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    cycle();
    reset_in = 1'b0;
    model_reset();
    cycle();
  endtask

  // inj_kind 1: rd_start pulse (no ack) before byte inj_at; 2: unlocking measurement with the ack of byte inj_at
  task automatic read_body(input int inj_at, input int inj_kind);
    for (int i = 0; i < 8; i++) begin
      if (i == inj_at && inj_kind == 1) begin
        rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
      end
      got_b[i] = rd_data;
      got_v[i] = rd_valid;
      rd_ack = 1'b1;
      if (i == inj_at && inj_kind == 2) begin
        meas_valid = 1'b1; freq_error_in = 24'd100; pwm_in = 24'd100;
      end
      cycle();
      rd_ack = 1'b0;
      meas_valid = 1'b0;
      if (i == 7) begin
        m_seq = (m_seq + 1) % 16;
        m_sticky = 0;
      end
      if (i == inj_at && inj_kind == 2) model_meas(100, 100);
    end
    end_v = rd_valid;
  endtask

  task automatic read_frame();
    rd_start = 1'b1;
    cycle();
    rd_start = 1'b0;
    read_body(-1, 0);
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    cycle(); cycle();
    n_checks++; if (locked !== 1'b0) begin $display("FAIL reset_locked: got %b expected 0", locked); n_fail++; end
    n_checks++; if (unlock_events !== 8'd0) begin $display("FAIL reset_unlock_events: got %0d expected 0", unlock_events); n_fail++; end
    n_checks++; if (rd_valid !== 1'b0) begin $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); n_fail++; end
    n_checks++; if (rd_data !== 8'd0) begin $display("FAIL reset_rd_data: got %h expected 00", rd_data); n_fail++; end
    reset_in = 1'b0;
    model_reset();
    cycle();
  endtask

  task automatic test_lock_acquisition();
    int errs[4] = '{1, -2, 0, 2};
    foreach (errs[i]) begin
      meas(errs[i], 1000);
      n_checks++; if (locked !== m_locked) begin $display("FAIL acq_locked[%0d]: got %b expected %b", i, locked, m_locked); n_fail++; end
    end
    n_checks++; if (unlock_events !== 8'(m_ue)) begin $display("FAIL acq_unlock_events: got %0d expected %0d", unlock_events, m_ue); n_fail++; end
  endtask

  task automatic test_hysteresis();
    int errs[6] = '{5, -9, 1, -1, 2, 0};
    foreach (errs[i]) begin
      meas(errs[i], 2000);
      n_checks++; if (locked !== m_locked) begin $display("FAIL hyst_locked[%0d]: got %b expected %b", i, locked, m_locked); n_fail++; end
      n_checks++; if (unlock_events !== 8'(m_ue)) begin $display("FAIL hyst_unlock_events[%0d]: got %0d expected %0d", i, unlock_events, m_ue); n_fail++; end
    end
  endtask

  task automatic test_frame();
    do_reset();
    repeat (4) meas(0, 20000);
    meas(-9, 20000);
    meas(-3, 30000);
    for (int f = 0; f < 2; f++) begin
      model_frame();
      read_frame();
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (got_b[i] !== exp_b[i] || got_v[i] !== 1'b1) begin
          $display("FAIL frame%0d_byte%0d: got %h valid %b expected %h valid 1", f, i, got_b[i], got_v[i], exp_b[i]); n_fail++;
        end
      end
      n_checks++; if (end_v !== 1'b0) begin $display("FAIL frame%0d_end_valid: got %b expected 0", f, end_v); n_fail++; end
    end
  endtask

  task automatic test_rails();
    int pw[6] = '{0, -5, 1, 49151, 49152, 60000};
    foreach (pw[k]) begin
      meas(0, pw[k]);
      model_frame();
      read_frame();
      n_checks++;
      if (got_b[0] !== exp_b[0]) begin $display("FAIL rails_byte0 pwm=%0d: got %h expected %h", pw[k], got_b[0], exp_b[0]); n_fail++; end
      n_checks++;
      if (got_b[4] !== exp_b[4] || got_b[5] !== exp_b[5] || got_b[6] !== exp_b[6]) begin
        $display("FAIL rails_pwm pwm=%0d: got %h%h%h expected %h%h%h", pw[k], got_b[4], got_b[5], got_b[6], exp_b[4], exp_b[5], exp_b[6]); n_fail++;
      end
    end
  endtask

  task automatic test_saturation();
    repeat (4) meas(1, 100);
    meas(-8388608, 100);
    n_checks++; if (locked !== m_locked) begin $display("FAIL sat_minneg_locked: got %b expected %b", locked, m_locked); n_fail++; end
    n_checks++; if (unlock_events !== 8'(m_ue)) begin $display("FAIL sat_minneg_events: got %0d expected %0d", unlock_events, m_ue); n_fail++; end
    for (int k = 0; k < 300; k++) begin
      repeat (4) meas(0, 100);
      meas(((k % 2) == 0) ? -8388608 : int'($urandom_range(9, 8388607)), 100);
      n_checks++;
      if (unlock_events !== 8'(m_ue) || locked !== m_locked) begin
        $display("FAIL sat_loop[%0d]: got events %0d locked %b expected %0d %b", k, unlock_events, locked, m_ue, m_locked); n_fail++;
      end
    end
  endtask

  task automatic test_collisions();
    // measurement on the rd_start edge must not leak into the snapshot
    model_frame();
    meas_valid = 1'b1; freq_error_in = 24'(-7); pwm_in = 24'd4321; rd_start = 1'b1;
    cycle();
    meas_valid = 1'b0; rd_start = 1'b0;
    model_meas(-7, 4321);
    read_body(-1, 0);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_b[i] !== exp_b[i]) begin $display("FAIL coll_start_byte%0d: got %h expected %h", i, got_b[i], exp_b[i]); n_fail++; end
    end
    // rd_start mid-frame is ignored
    model_frame();
    rd_start = 1'b1; cycle(); rd_start = 1'b0;
    read_body(3, 1);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_b[i] !== exp_b[i] || got_v[i] !== 1'b1) begin $display("FAIL coll_midstart_byte%0d: got %h valid %b expected %h", i, got_b[i], got_v[i], exp_b[i]); n_fail++; end
    end
    // rd_ack while idle is ignored
    rd_ack = 1'b1; cycle(); rd_ack = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) begin $display("FAIL coll_idle_ack: got %b expected 0", rd_valid); n_fail++; end
    // unlock on the final-ack edge keeps sticky set
    repeat (4) meas(0, 500);
    model_frame();
    rd_start = 1'b1; cycle(); rd_start = 1'b0;
    read_body(7, 2);
    n_checks++; if (end_v !== 1'b0) begin $display("FAIL coll_final_end_valid: got %b expected 0", end_v); n_fail++; end
    n_checks++; if (locked !== m_locked) begin $display("FAIL coll_final_locked: got %b expected %b", locked, m_locked); n_fail++; end
    model_frame();
    read_frame();
    n_checks++; if (got_b[0] !== exp_b[0]) begin $display("FAIL coll_sticky_byte0: got %h expected %h", got_b[0], exp_b[0]); n_fail++; end
    n_checks++; if (got_b[7] !== exp_b[7]) begin $display("FAIL coll_sticky_byte7: got %h expected %h", got_b[7], exp_b[7]); n_fail++; end
  endtask

  task automatic test_reset_midframe();
    repeat (4) meas(0, 700);
    rd_start = 1'b1; cycle(); rd_start = 1'b0;
    repeat (3) begin rd_ack = 1'b1; cycle(); rd_ack = 1'b0; end
    n_checks++; if (rd_valid !== 1'b1) begin $display("FAIL midrst_pre_valid: got %b expected 1", rd_valid); n_fail++; end
    #2 reset_in = 1'b1;
    #1;
    n_checks++; if (rd_valid !== 1'b0) begin $display("FAIL midrst_rd_valid: got %b expected 0", rd_valid); n_fail++; end
    n_checks++; if (rd_data !== 8'd0) begin $display("FAIL midrst_rd_data: got %h expected 00", rd_data); n_fail++; end
    n_checks++; if (locked !== 1'b0) begin $display("FAIL midrst_locked: got %b expected 0", locked); n_fail++; end
    n_checks++; if (unlock_events !== 8'd0) begin $display("FAIL midrst_events: got %0d expected 0", unlock_events); n_fail++; end
    cycle();
    reset_in = 1'b0;
    model_reset();
    cycle();
    model_frame();
    read_frame();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_b[i] !== exp_b[i]) begin $display("FAIL midrst_frame_byte%0d: got %h expected %h", i, got_b[i], exp_b[i]); n_fail++; end
    end
  endtask

  task automatic test_random();
    int e, p, sel, mag;
    for (int k = 0; k < 400; k++) begin
      sel = int'($urandom_range(0, 3));
      if (sel <= 1) e = int'($urandom_range(0, 4)) - 2;
      else begin
        mag = (sel == 2) ? int'($urandom_range(3, 8)) : int'($urandom_range(9, 8388607));
        e = $urandom_range(0, 1) ? mag : -mag;
        if (sel == 3 && $urandom_range(0, 15) == 0) e = -8388608;
      end
      p = int'($urandom_range(0, 49200)) - 20;
      meas(e, p);
      repeat ($urandom_range(0, 2)) cycle();
      n_checks++;
      if (locked !== m_locked || unlock_events !== 8'(m_ue)) begin
        $display("FAIL rand_status[%0d]: got locked %b events %0d expected %b %0d", k, locked, unlock_events, m_locked, m_ue); n_fail++;
      end
      if (k % 40 == 39) begin
        model_frame();
        read_frame();
        for (int i = 0; i < 8; i++) begin
          n_checks++;
          if (got_b[i] !== exp_b[i]) begin $display("FAIL rand_frame%0d_byte%0d: got %h expected %h", k, i, got_b[i], exp_b[i]); n_fail++; end
        end
      end
    end
  endtask

  task automatic test_avg_pattern();
    do_reset();
    meas(4, 100); meas(8, 100); meas(-4, 100); meas(12, 100);
    model_frame();
    read_frame();
    n_checks++;
    if ({got_b[1], got_b[2], got_b[3]} !== {exp_b[1], exp_b[2], exp_b[3]}) begin
      $display("FAIL avg_err_field: got %h%h%h expected %h%h%h", got_b[1], got_b[2], got_b[3], exp_b[1], exp_b[2], exp_b[3]); n_fail++;
    end
  endtask

  initial begin
    reset_in = 1'b0; meas_valid = 1'b0; rd_start = 1'b0; rd_ack = 1'b0;
    freq_error_in = '0; pwm_in = '0;
    model_reset();
    test_reset();
    test_lock_acquisition();
    test_hysteresis();
    test_frame();
    test_rails();
    test_saturation();
    test_collisions();
    test_reset_midframe();
    test_random();
    test_avg_pattern();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
